// File: rtl/multicycle_data_path.sv
// Multi-cycle ARM-subset datapath with one shared memory port.
// A phase FSM steps FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK; an external control unit drives the static controls.
module multicycle_data_path #(
  parameter int               WIDTH    = 32,
  parameter int               REG_ADDR = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             is_mem,
  input  logic             is_branch,
  input  logic             cond_pass,
  input  logic             reg_write,
  input  logic             mem_write,
  input  logic             flag_write,
  input  logic             alu_src,
  input  logic [1:0]       imm_src,
  input  logic [1:0]       reg_src,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [WIDTH-1:0] instruction,
  output logic [3:0]       alu_flags,
  output logic [WIDTH-1:0] pc,
  output logic [2:0]       phase
);

  localparam int                  NREGS  = 2 ** REG_ADDR;
  localparam logic [REG_ADDR-1:0] PC_IDX = '1;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4
  } phase_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_ORR = 4'b0011,
    ALU_EOR = 4'b0100,
    ALU_MOV = 4'b0101
  } alu_op_t;

  phase_t state;
  phase_t state_next;

  // Inter-phase latches
  logic [WIDTH-1:0] ir;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] mdr;
  logic [3:0]       flags;

  logic [WIDTH-1:0] regs [NREGS];

  logic [REG_ADDR-1:0] a1;
  logic [REG_ADDR-1:0] a2;
  logic [REG_ADDR-1:0] rd;
  logic [WIDTH-1:0]    pc_plus4;
  logic [WIDTH-1:0]    rd_a;
  logic [WIDTH-1:0]    rd_b;
  logic [WIDTH-1:0]    imm_ext;
  logic [WIDTH-1:0]    src_b;
  logic [WIDTH:0]      sum;
  logic [WIDTH:0]      diff;
  logic [WIDTH-1:0]    alu_result;
  logic                carry;
  logic                ovf;
  logic [3:0]          nzcv;
  logic [WIDTH-1:0]    wb_result;

  // ---------------------------------------------------------------------------
  // Register-file read and operand selection
  // ---------------------------------------------------------------------------
  assign a1       = reg_src[0] ? PC_IDX : ir[16 +: REG_ADDR];
  assign a2       = reg_src[1] ? ir[12 +: REG_ADDR] : ir[0 +: REG_ADDR];
  assign rd       = ir[12 +: REG_ADDR];
  assign pc_plus4 = pc + WIDTH'(4);

  // pc has already advanced past the fetch, so the alias reads fetch address + 8
  assign rd_a = (a1 == PC_IDX) ? pc_plus4 : regs[a1];
  assign rd_b = (a2 == PC_IDX) ? pc_plus4 : regs[a2];

  // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    imm_ext = '0;
    case (imm_src)
      2'b00:   imm_ext = WIDTH'(ir[7:0]);
      2'b01:   imm_ext = WIDTH'(ir[11:0]);
      2'b10:   imm_ext = {{(WIDTH-26){ir[23]}}, ir[23:0], 2'b00};
      default: imm_ext = '0;
    endcase
  end

  assign src_b = alu_src ? imm_ext : b;

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  assign sum  = {1'b0, a} + {1'b0, src_b};
  assign diff = {1'b0, a} - {1'b0, src_b};

  always_comb begin
    alu_result = '0;
    carry      = 1'b0;
    ovf        = 1'b0;
    case (alu_op_t'(alu_control))
      ALU_ADD: begin
        alu_result = sum[WIDTH-1:0];
        carry      = sum[WIDTH];
        ovf        = (a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_result = diff[WIDTH-1:0];
        carry      = ~diff[WIDTH];  // no borrow
        ovf        = (a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: alu_result = a & src_b;
      ALU_ORR: alu_result = a | src_b;
      ALU_EOR: alu_result = a ^ src_b;
      ALU_MOV: alu_result = src_b;
      default: alu_result = '0;
    endcase
  end

  assign nzcv      = {alu_result[WIDTH-1], (alu_result == '0), carry, ovf};
  assign wb_result = is_mem ? mdr : alu_out;

  // ---------------------------------------------------------------------------
  // Phase FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      FETCH:     if (mem_ready) state_next = DECODE;
      DECODE:    state_next = EXECUTE;
      EXECUTE: begin
        if (is_branch)   state_next = FETCH;
        else if (is_mem) state_next = cond_pass ? MEMORY : FETCH;
        else             state_next = WRITEBACK;
      end
      MEMORY:    if (mem_ready) state_next = mem_write ? FETCH : WRITEBACK;
      WRITEBACK: state_next = FETCH;
      default:   state_next = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state <= FETCH;
    else      state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Datapath latches, PC and flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      flags   <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata;
            pc <= pc_plus4;
          end
        end
        DECODE: begin
          a <= rd_a;
          b <= rd_b;
        end
        EXECUTE: begin
          alu_out <= alu_result;
          if (flag_write && cond_pass) flags <= nzcv;
          if (is_branch && cond_pass)  pc    <= alu_result;
        end
        MEMORY: begin
          if (mem_ready && !mem_write) mdr <= mem_rdata;
        end
        WRITEBACK: begin
          if (reg_write && cond_pass && rd == PC_IDX) pc <= wb_result;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the register file is cleared on reset because software expects every register to read zero afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (state == WRITEBACK && reg_write && cond_pass && rd != PC_IDX) begin
      regs[rd] <= wb_result;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory port and observation outputs
  // ---------------------------------------------------------------------------
  // Gating with rst drops any in-flight request the moment reset is asserted.
  assign mem_req     = rst && (state == FETCH || state == MEMORY);
  assign mem_we      = mem_req && (state == MEMORY) && mem_write;
  assign mem_addr    = (state == MEMORY) ? alu_out : pc;
  assign mem_wdata   = b;
  assign instruction = ir;
  assign alu_flags   = flags;
  assign phase       = state;

endmodule
